// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared state type, burst constants and sizing helper
// for the DDR burst arbiter.
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_CMD,
    RD_CMD,
    RD_DATA,
    DONE
  } arb_state_e;

  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned BURST_LEN_DEF = 32;
  localparam int unsigned BURST_BYTES   = BURST_LEN_DEF * WORD_BYTES;

  // Ceil log2, never below 1 so it can size an index vector.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

  localparam int unsigned ALIGN_BITS = clog2(BURST_BYTES);

endpackage

// File: rtl/ddr_rr_picker.sv
// ddr_rr_picker: combinational round-robin select, first active
// request at or after the pointer, wrapping modulo NUM_REQ.
module ddr_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned k;
    k   = 0;
    any = 1'b0;
    gnt = '0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: round-robin burst scheduler onto the DDR app port.
// Optional read watchdog enabled by DDR_BURST_ARB_TIMEOUT_EN.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned ADDR_WIDTH  = 30,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                         c1_clk0,
  input  logic                         c1_rst0,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           wdata_pop,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [NUM_REQ-1:0]           rd_valid,
  output logic [NUM_REQ-1:0]           cmp_done,
  output logic                         cmp_err,
  output logic                         busy,
  input  logic                         app_w_enable,
  input  logic                         app_r_enable,
  output logic [ADDR_WIDTH-1:0]        app_addr_wr,
  output logic                         app_addr_wr_valid,
  output logic [DATA_WIDTH-1:0]        app_data_wr,
  output logic                         app_data_wr_valid,
  output logic [ADDR_WIDTH-1:0]        app_addr_rd,
  output logic                         app_addr_rd_valid,
  input  logic [DATA_WIDTH-1:0]        app_data_rd,
  input  logic                         app_data_rd_valid
);

  localparam int unsigned IDX_W   = clog2(NUM_REQ);
  localparam int unsigned BEAT_W  = clog2(BURST_LEN);
  localparam int unsigned ALIGN_W = clog2(BURST_LEN * WORD_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_W) - ADDR_WIDTH'(1));

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("ddr_burst_arbiter: unsupported parameter set");
  end

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d, rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
  logic                  drop_q, drop_d;
  logic                  pick_any;
  logic [NUM_REQ-1:0]    pick_gnt, gnt_oh;
  logic [IDX_W-1:0]      pick_idx;
  logic                  last_beat;

`ifdef DDR_BURST_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = clog2(TIMEOUT_CYC) + 1;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`endif

  ddr_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_q),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign gnt_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
  assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));

  always_comb begin
    state_d           = state_q;
    gnt_d             = gnt_q;
    rr_d              = rr_q;
    addr_d            = addr_q;
    beat_d            = beat_q;
    rd_data_d         = rd_data_q;
    rd_valid_d        = '0;
    drop_d            = drop_q;
    wdata_pop         = '0;
    app_data_wr_valid = 1'b0;
    app_data_wr       = '0;
    app_addr_wr_valid = 1'b0;
    app_addr_wr       = '0;
    app_addr_rd_valid = 1'b0;
    app_addr_rd       = '0;
    cmp_done          = '0;
`ifdef DDR_BURST_ARB_TIMEOUT_EN
    to_d              = to_q;
    err_d             = err_q;
`endif
    // Stray read returns are discarded but remembered.
    if (app_data_rd_valid && state_q != RD_DATA) drop_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d  = pick_idx;
          addr_d = req_addr[32'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                   & ALIGN_MASK;
          beat_d = '0;
`ifdef DDR_BURST_ARB_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          state_d = |(req_we & pick_gnt) ? WR_DATA : RD_CMD;
        end
      end
      WR_DATA: begin
        if (app_w_enable) begin
          app_data_wr_valid = 1'b1;
          app_data_wr = req_wdata[32'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
          wdata_pop   = gnt_oh;
          beat_d      = beat_q + 1'b1;
          if (last_beat) begin
            beat_d  = '0;
            state_d = WR_CMD;
          end
        end
      end
      WR_CMD: begin
        if (app_w_enable) begin
          app_addr_wr_valid = 1'b1;
          app_addr_wr       = addr_q;
          state_d           = DONE;
        end
      end
      RD_CMD: begin
        if (app_r_enable) begin
          app_addr_rd_valid = 1'b1;
          app_addr_rd       = addr_q;
          beat_d            = '0;
`ifdef DDR_BURST_ARB_TIMEOUT_EN
          to_d              = TO_W'(1);
`endif
          state_d           = RD_DATA;
        end
      end
      RD_DATA: begin
        if (app_data_rd_valid) begin
          rd_valid_d = gnt_oh;
          rd_data_d  = app_data_rd;
          beat_d     = beat_q + 1'b1;
`ifdef DDR_BURST_ARB_TIMEOUT_EN
          to_d       = TO_W'(1);
`endif
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
          end
        end
`ifdef DDR_BURST_ARB_TIMEOUT_EN
        // to_q counts cycles since the last beat or the command.
        else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      DONE: begin
        cmp_done = gnt_oh;
        rr_d     = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge c1_clk0) begin
    if (c1_rst0) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_q       <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      drop_q     <= drop_d;
    end
  end

`ifdef DDR_BURST_ARB_TIMEOUT_EN
  always_ff @(posedge c1_clk0) begin
    if (c1_rst0) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end

  assign cmp_err = (state_q == DONE) && err_q;
`else
  assign cmp_err = 1'b0;
`endif

  assign busy     = (state_q != IDLE);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
